pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumer end of the clock-generation PLL's control/status interface.
- Drives the PLL's areset request, watches its asynchronous locked output, and releases a synchronous system reset only after lock has been stable for a programmed time.
- Detects loss of lock, re-arms the PLL, counts events, and declares a sticky failure after repeated lock timeouts.
- Runs on the 10 MHz reference clock, the same clock that feeds the PLL input.

Parameters:
- PLL_RST_CYCLES, 10: cycles pll_areset is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 10000: cycles allowed for locked to rise after pll_areset drops (1 ms at 10 MHz).
- STABLE_CYCLES, 1000: consecutive synchronized locked=1 samples required before release (100 us).
- MAX_RETRIES, 3: consecutive lock timeouts before FAIL (>=1).
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  reference clock, 10 MHz.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked flag, asynchronous to clk.
- clr_stats  in  1  single-cycle pulse; clears lock_loss_cnt and timeout_cnt.
- pll_areset  out  1  reset request to the PLL, active high.
- sys_rst  out  1  synchronous reset for PLL-clocked logic, active high.
- ready  out  1  high only in RUN.
- fail  out  1  sticky; PLL failed to lock MAX_RETRIES consecutive times.
- state_o  out  3  current state encoding (debug).
- lock_loss_cnt  out  CNT_W  RUN->LOST transitions, saturating.
- timeout_cnt  out  CNT_W  lock timeouts, saturating.

Behaviour:
- Synchronization:
  - pll_locked passes through a 2-flop synchronizer to give locked_s; latency is 2 cycles.
  - The FSM uses only locked_s.
  - Synchronizer flops reset to 0.
- Outputs: all are registered and Moore-decoded from the state register.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, LOST=4, FAIL=5.
- Reset values:
  - state=PLL_RST, pll_areset=1, sys_rst=1, ready=0, fail=0.
  - Both counters 0, retry count 0, timer 0.
  - rst asserted in any state, including mid-sequence, returns to these values on the next edge.
- PLL_RST:
  - pll_areset=1, sys_rst=1.
  - Timer counts 0..PLL_RST_CYCLES-1, then goes to WAIT_LOCK with the timer cleared.
  - pll_areset is therefore high exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_areset=0, sys_rst=1.
  - If locked_s=1, go to STABLE with the timer cleared.
  - Else, when the timer reaches LOCK_TIMEOUT-1:
    - timeout_cnt increments (saturating); retry count increments.
    - If the retry count then equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
  - If locked_s rises in the same cycle the timeout expires, lock wins: go to STABLE, no timeout counted.
- STABLE:
  - sys_rst=1.
  - Timer increments while locked_s=1.
  - locked_s=0 returns to WAIT_LOCK with the timer cleared; the timeout window restarts and no event is counted.
  - When the timer reaches STABLE_CYCLES-1 with locked_s=1, go to RUN and clear the retry count.
  - RUN is entered after exactly STABLE_CYCLES consecutive high samples.
- RUN:
  - sys_rst=0, ready=1.
  - locked_s=0 goes to LOST.
- LOST:
  - Lasts one cycle; sys_rst=1, ready=0.
  - lock_loss_cnt increments (saturating), then go to PLL_RST.
- FAIL:
  - pll_areset=1, sys_rst=1, fail=1.
  - Terminal; only rst exits.
  - locked_s is ignored.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_stats clears both counters on the next edge.
  - clr_stats coincident with an increment: clear wins, result 0.
  - clr_stats does not affect the FSM, fail or the retry count.
- Glitches: a locked_s low pulse of 1 cycle in RUN is a loss; no filtering in RUN.

Test Plan:
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Nominal bring-up: rst released, pll_locked=1 applied 3 cycles after pll_areset falls -> pll_areset high exactly 4 cycles; ready=1 and sys_rst=0 on the 8th cycle after locked_s rises (locked_s = pll_locked delayed 2); counters 0.
2. Unstable lock: pll_locked high 5 cycles, low 1, then high -> STABLE aborts to WAIT_LOCK; RUN reached only after 8 new consecutive samples; timeout_cnt=0.
3. Loss in RUN: drop pll_locked for 1 cycle -> LOST for 1 cycle, lock_loss_cnt=1, pll_areset high 4 cycles, sys_rst=1 until relock plus 8 cycles.
4. Timeout and fail: pll_locked held 0 -> timeout_cnt=1 after 20 WAIT_LOCK cycles, PLL_RST re-entered; second timeout -> timeout_cnt=2, fail=1, state_o=5; later pll_locked=1 ignored; rst returns all outputs to reset values.
5. Timeout/lock race and clear: locked_s rising on timer=19 -> STABLE, timeout_cnt unchanged; clr_stats coincident with the LOST increment -> lock_loss_cnt=0.
6. Saturation: CNT_W=2 build, 5 loss events -> lock_loss_cnt=3; rst asserted while in STABLE -> next edge state_o=0, pll_areset=1.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Consumer-side supervisor for the clock-generation PLL. Runs on the same
// reference clock that feeds the PLL input. It pulses the PLL areset, waits for
// the (asynchronous) locked flag, requires lock to be stable for a programmed
// number of samples before releasing the system reset, and re-arms the PLL on
// loss of lock. Repeated lock timeouts end in a sticky FAIL state.
//
// Ports
//   clk            reference clock (10 MHz)
//   rst            synchronous active-high reset
//   pll_locked     PLL locked flag, asynchronous to clk
//   clr_stats      one-cycle pulse, clears lock_loss_cnt and timeout_cnt
//   pll_areset     reset request to the PLL, active high
//   sys_rst        reset for PLL-clocked logic, active high
//   ready          high only in RUN
//   fail           sticky failure after MAX_RETRIES consecutive timeouts
//   state_o        current state encoding (debug)
//   lock_loss_cnt  RUN->LOST transitions, saturating
//   timeout_cnt    lock timeouts, saturating
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 10,
    parameter int LOCK_TIMEOUT   = 10000,
    parameter int STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clr_stats,
    output logic             pll_areset,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // One shared timer, sized for the longest interval it has to measure.
    localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int RW     = $clog2(MAX_RETRIES + 1);

    // The sample that moves WAIT_LOCK into STABLE is the first of the
    // STABLE_CYCLES consecutive high samples, so in STABLE the timer holds
    // (high samples so far - 1) and RUN is taken when it would reach
    // STABLE_CYCLES-1.
    localparam int STB_LAST = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

    localparam logic [TW-1:0] PRST_END = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_END  = TW'(STB_LAST);
    localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRIES);

    // 2-flop synchronizer for the asynchronous locked flag.
    logic [1:0] sync_pipe;
    logic       locked_s;
    assign locked_s = sync_pipe[1];

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [RW-1:0]   retry, retry_n, retry_inc;
    logic            loss_inc, tmo_inc;

    assign retry_inc = retry + 1'b1;
    assign state_o   = state;

    // Next-state / timer / event decode.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        retry_n  = retry;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (timer == PRST_END) begin
                    state_n = S_WAIT_LOCK;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is checked first so it wins a race with the timeout.
                if (locked_s) begin
                    state_n = S_STABLE;
                    timer_n = '0;
                end else if (timer == TMO_END) begin
                    tmo_inc = 1'b1;
                    timer_n = '0;
                    retry_n = retry_inc;
                    state_n = (retry_inc == RETRY_MX) ? S_FAIL : S_PLL_RST;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_n = S_WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == STB_END) begin
                    state_n = S_RUN;
                    timer_n = '0;
                    retry_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_n = S_LOST;
                end
            end
            S_LOST: begin
                loss_inc = 1'b1;
                state_n  = S_PLL_RST;
                timer_n  = '0;
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_PLL_RST;
                timer_n = '0;
            end
        endcase
    end

    // Registers. Outputs are decoded from the next state so each one is a
    // flop that changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe     <= '0;
            state         <= S_PLL_RST;
            timer         <= '0;
            retry         <= '0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
            pll_areset    <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], pll_locked};
            state     <= state_n;
            timer     <= timer_n;
            retry     <= retry_n;

            // Clear has priority over a coincident increment.
            if (clr_stats)
                lock_loss_cnt <= '0;
            else if (loss_inc && (lock_loss_cnt != '1))
                lock_loss_cnt <= lock_loss_cnt + 1'b1;

            if (clr_stats)
                timeout_cnt <= '0;
            else if (tmo_inc && (timeout_cnt != '1))
                timeout_cnt <= timeout_cnt + 1'b1;

            pll_areset <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
            sys_rst    <= (state_n != S_RUN);
            ready      <= (state_n == S_RUN);
            fail       <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4,
// LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2 and CNT_W=2 (narrow counters
// so saturation is reachable). Inputs are driven and outputs sampled on the
// falling edge; expected values go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          clr_stats;
    logic          pll_areset;
    logic          sys_rst;
    logic          ready;
    logic          fail;
    logic [2:0]    state_o;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .clr_stats     (clr_stats),
        .pll_areset    (pll_areset),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fail          (fail),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
        push_exp(tag, val);
        pop_cmp(obs);
    endtask

    // Counts falling edges on which state_o still equals s (bounded).
    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (state_o == s && n < 1000) begin
            n++;
            tick(1);
        end
    endtask

    task automatic count_areset(output int n);
        n = 0;
        while (pll_areset && n < 1000) begin
            n++;
            tick(1);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            n++;
            tick(1);
        end
        chk(tag, ready, 1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s);
        int n;
        n = 0;
        while (state_o != s && n < 200) begin
            n++;
            tick(1);
        end
        chk(tag, state_o, s);
    endtask

    // One-cycle drop of pll_locked; returns on the falling edge where the
    // FSM has just moved LOST -> PLL_RST.
    task automatic loss_pulse();
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_stats  = 1'b0;
        tick(3);

        // ---- reset state
        chk("rst_state",   state_o, 0);
        chk("rst_areset",  pll_areset, 1);
        chk("rst_sysrst",  sys_rst, 1);
        chk("rst_ready",   ready, 0);
        chk("rst_fail",    fail, 0);
        chk("rst_losscnt", lock_loss_cnt, 0);
        chk("rst_tmocnt",  timeout_cnt, 0);

        // ---- 1: nominal bring-up
        rst = 1'b0;
        count_areset(n);
        chk("s1_areset_len", n, 4);
        chk("s1_wait_state", state_o, 1);
        tick(3);
        pll_locked = 1'b1;
        // locked_s rises 2 edges later; RUN on the 8th edge after that.
        push_exp("s1_ready_early", 0);
        push_exp("s1_ready", 1);
        push_exp("s1_sysrst", 0);
        tick(9);
        pop_cmp(ready);
        tick(1);
        pop_cmp(ready);
        pop_cmp(sys_rst);
        chk("s1_state", state_o, 3);
        chk("s1_losscnt", lock_loss_cnt, 0);
        chk("s1_tmocnt", timeout_cnt, 0);

        // ---- 2: unstable lock aborts STABLE
        do_reset();
        pll_locked = 1'b0;
        rst = 1'b0;
        count_areset(n);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("s2_back_to_wait", state_o, 1);
        tick(7);
        chk("s2_ready_early", ready, 0);
        tick(1);
        chk("s2_ready", ready, 1);
        chk("s2_tmocnt", timeout_cnt, 0);

        // ---- 3: loss in RUN
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("s3_lost_state", state_o, 4);
        chk("s3_lost_ready", ready, 0);
        chk("s3_lost_sysrst", sys_rst, 1);
        tick(1);
        chk("s3_prst_state", state_o, 0);
        chk("s3_losscnt", lock_loss_cnt, 1);
        count_areset(n);
        chk("s3_areset_len", n, 4);
        tick(7);
        chk("s3_sysrst_held", sys_rst, 1);
        tick(1);
        chk("s3_sysrst_rel", sys_rst, 0);
        chk("s3_ready", ready, 1);

        // ---- 4: timeouts and FAIL
        pll_locked = 1'b0;
        tick(4);
        chk("s4_prst", state_o, 0);
        count_state(3'd0, n);
        chk("s4_prst_len", n, 4);
        count_state(3'd1, n);
        chk("s4_wait_len1", n, 20);
        chk("s4_rearm_state", state_o, 0);
        chk("s4_tmocnt1", timeout_cnt, 1);
        chk("s4_nofail", fail, 0);
        count_state(3'd0, n);
        count_state(3'd1, n);
        chk("s4_wait_len2", n, 20);
        chk("s4_fail_state", state_o, 5);
        chk("s4_fail", fail, 1);
        chk("s4_tmocnt2", timeout_cnt, 2);
        chk("s4_fail_areset", pll_areset, 1);
        chk("s4_fail_sysrst", sys_rst, 1);
        pll_locked = 1'b1;
        tick(12);
        chk("s4_fail_sticky", state_o, 5);
        chk("s4_fail_ready", ready, 0);
        rst = 1'b1;
        tick(1);
        chk("s4_rst_state", state_o, 0);
        chk("s4_rst_fail", fail, 0);
        chk("s4_rst_areset", pll_areset, 1);
        chk("s4_rst_tmocnt", timeout_cnt, 0);
        chk("s4_rst_losscnt", lock_loss_cnt, 0);

        // ---- 5: lock/timeout race, then clear vs increment
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
        count_areset(n);
        // timer=0 now; locked_s must first be seen with timer=19.
        tick(17);
        pll_locked = 1'b1;
        tick(2);
        chk("s5_still_wait", state_o, 1);
        tick(1);
        chk("s5_race_stable", state_o, 2);
        chk("s5_race_tmocnt", timeout_cnt, 0);
        tick(7);
        chk("s5_ready", ready, 1);
        loss_pulse();
        chk("s5_losscnt1", lock_loss_cnt, 1);
        wait_ready("s5_relock");
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("s5_lost", state_o, 4);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        chk("s5_clr_state", state_o, 0);
        chk("s5_clr_losscnt", lock_loss_cnt, 0);

        // ---- 6: saturation, then reset out of STABLE
        for (int i = 0; i < 5; i++) begin
            wait_ready("s6_ready");
            loss_pulse();
            if (i == 2)
                chk("s6_losscnt3", lock_loss_cnt, 3);
        end
        chk("s6_sat", lock_loss_cnt, 3);
        wait_state("s6_stable", 3'd2);
        rst = 1'b1;
        tick(1);
        chk("s6_rst_state", state_o, 0);
        chk("s6_rst_areset", pll_areset, 1);
        chk("s6_rst_losscnt", lock_loss_cnt, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
